// File: rtl/axi2mem_pkg.sv
// Shared encodings for the TCDM read-burst scheduler: AXI burst types and FSM states.
package axi2mem_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

endpackage

// File: rtl/axi2mem_burst_addr_gen.sv
// Combinational 64-bit beat address for a given beat index of an AXI burst.
module axi2mem_burst_addr_gen
    import axi2mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic [7:0]            len_i,
    input  logic [1:0]            burst_i,
    input  logic [7:0]            beat_cnt_i,
    output logic [ADDR_WIDTH-1:0] beat_addr_o
);

    logic [ADDR_WIDTH-1:0] incr_addr;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic                  wrap_ok;

    assign incr_addr = base_i + (ADDR_WIDTH'(beat_cnt_i) << 3);
    assign wrap_ok   = (len_i == 8'd1) || (len_i == 8'd3) || (len_i == 8'd7) || (len_i == 8'd15);
    assign wrap_mask = ((ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << 3) - ADDR_WIDTH'(1);

    // Illegal WRAP lengths and the reserved encoding fall back to INCR.
    always_comb begin
        beat_addr_o = incr_addr;
        if (burst_i == BURST_FIXED) begin
            beat_addr_o = base_i;
        end else if ((burst_i == BURST_WRAP) && wrap_ok) begin
            beat_addr_o = (base_i & ~wrap_mask) | (incr_addr & wrap_mask);
        end
    end

endmodule

// File: rtl/axi2mem_tcdm_rd_sched.sv
// Expands one AXI AR burst at a time into per-beat commands on two 32-bit TCDM read lanes.
module axi2mem_tcdm_rd_sched
    import axi2mem_pkg::*;
#(
    parameter int ID_WIDTH   = 6,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           ar_valid_i,
    output logic                           ar_ready_o,
    input  logic [ADDR_WIDTH-1:0]          ar_addr_i,
    input  logic [7:0]                     ar_len_i,
    input  logic [1:0]                     ar_burst_i,
    input  logic [ID_WIDTH-1:0]            ar_id_i,
    output logic [1:0]                     trans_rd_req_o,
    input  logic [1:0]                     trans_rd_gnt_i,
    output logic [1:0][ADDR_WIDTH-1:0]     trans_rd_add_o,
    output logic [1:0][ID_WIDTH-1:0]       trans_rd_id_o,
    output logic [1:0]                     trans_rd_last_o,
    output logic                           busy_o
);

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  base_q, base_d;
    logic [7:0]             len_q, len_d;
    logic [1:0]             burst_q, burst_d;
    logic [ID_WIDTH-1:0]    id_q, id_d;
    logic [7:0]             beat_cnt_q, beat_cnt_d;
    logic [1:0]             lane_done_q, lane_done_d;
    logic [1:0]             req_q, req_d;
    logic                   last_q, last_d;
    logic                   busy_q, busy_d;
    logic [1:0][ADDR_WIDTH-1:0] add_q, add_d;

    logic [ADDR_WIDTH-1:0]  ar_base;
    logic [ADDR_WIDTH-1:0]  gen_base;
    logic [7:0]             gen_len;
    logic [1:0]             gen_burst;
    logic [7:0]             gen_cnt;
    logic [ADDR_WIDTH-1:0]  gen_addr;
    logic [1:0]             lane_cmp;
    logic                   load_beat;
    logic                   unused_addr_bits;

    // Sub-beat byte offset is resolved by the data path, not here.
    assign ar_base          = {ar_addr_i[ADDR_WIDTH-1:3], 3'b000};
    assign unused_addr_bits = ^ar_addr_i[2:0];
    assign lane_cmp         = lane_done_q | trans_rd_gnt_i;

    axi2mem_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .base_i      (gen_base),
        .len_i       (gen_len),
        .burst_i     (gen_burst),
        .beat_cnt_i  (gen_cnt),
        .beat_addr_o (gen_addr)
    );

    // The address generator always looks one beat ahead so lane outputs can be registered.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        burst_d     = burst_q;
        id_d        = id_q;
        beat_cnt_d  = beat_cnt_q;
        lane_done_d = lane_done_q;
        req_d       = req_q;
        last_d      = last_q;
        busy_d      = busy_q;
        load_beat   = 1'b0;
        gen_base    = base_q;
        gen_len     = len_q;
        gen_burst   = burst_q;
        gen_cnt     = beat_cnt_q + 8'd1;

        case (state_q)
            ST_IDLE: begin
                gen_base  = ar_base;
                gen_len   = ar_len_i;
                gen_burst = ar_burst_i;
                gen_cnt   = 8'd0;
                if (ar_valid_i) begin
                    state_d     = ST_ISSUE;
                    base_d      = ar_base;
                    len_d       = ar_len_i;
                    burst_d     = ar_burst_i;
                    id_d        = ar_id_i;
                    beat_cnt_d  = 8'd0;
                    lane_done_d = 2'b00;
                    req_d       = 2'b11;
                    last_d      = (ar_len_i == 8'd0);
                    busy_d      = 1'b1;
                    load_beat   = 1'b1;
                end
            end
            ST_ISSUE: begin
                lane_done_d = lane_cmp;
                req_d       = ~lane_cmp;
                if (&lane_cmp) begin
                    lane_done_d = 2'b00;
                    if (last_q) begin
                        state_d = ST_IDLE;
                        req_d   = 2'b00;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                    end else begin
                        beat_cnt_d = gen_cnt;
                        req_d      = 2'b11;
                        last_d     = (gen_cnt == len_q);
                        load_beat  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_lane
            assign add_d[gi] = load_beat ? (gen_addr + ADDR_WIDTH'(gi * 4)) : add_q[gi];

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    add_q[gi] <= '0;
                end else begin
                    add_q[gi] <= add_d[gi];
                end
            end

            assign trans_rd_add_o[gi]  = add_q[gi];
            assign trans_rd_id_o[gi]   = id_q;
            assign trans_rd_last_o[gi] = last_q;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            len_q       <= '0;
            burst_q     <= '0;
            id_q        <= '0;
            beat_cnt_q  <= '0;
            lane_done_q <= '0;
            req_q       <= '0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            burst_q     <= burst_d;
            id_q        <= id_d;
            beat_cnt_q  <= beat_cnt_d;
            lane_done_q <= lane_done_d;
            req_q       <= req_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
        end
    end

    assign ar_ready_o     = (state_q == ST_IDLE);
    assign trans_rd_req_o = req_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_axi2mem_tcdm_rd_sched.sv
// Randomised and directed bench for the read-burst scheduler against a beat-level reference model.
module tb_axi2mem_tcdm_rd_sched;

    localparam int IDW = 6;
    localparam int AW  = 32;

    logic                 clk = 1'b0;
    logic                 rst_ni = 1'b0;
    logic                 ar_valid_i = 1'b0;
    logic                 ar_ready_o;
    logic [AW-1:0]        ar_addr_i = '0;
    logic [7:0]           ar_len_i = '0;
    logic [1:0]           ar_burst_i = '0;
    logic [IDW-1:0]       ar_id_i = '0;
    logic [1:0]           trans_rd_req_o;
    logic [1:0]           trans_rd_gnt_i = '0;
    logic [1:0][AW-1:0]   trans_rd_add_o;
    logic [1:0][IDW-1:0]  trans_rd_id_o;
    logic [1:0]           trans_rd_last_o;
    logic                 busy_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axi2mem_tcdm_rd_sched #(
        .ID_WIDTH   (IDW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .ar_valid_i      (ar_valid_i),
        .ar_ready_o      (ar_ready_o),
        .ar_addr_i       (ar_addr_i),
        .ar_len_i        (ar_len_i),
        .ar_burst_i      (ar_burst_i),
        .ar_id_i         (ar_id_i),
        .trans_rd_req_o  (trans_rd_req_o),
        .trans_rd_gnt_i  (trans_rd_gnt_i),
        .trans_rd_add_o  (trans_rd_add_o),
        .trans_rd_id_o   (trans_rd_id_o),
        .trans_rd_last_o (trans_rd_last_o),
        .busy_o          (busy_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference beat address: wrap expressed as modular offset inside an aligned window.
    function automatic logic [31:0] exp_addr(input logic [31:0] addr, input logic [7:0] len,
                                             input logic [1:0] burst, input int k);
        logic [31:0] a, wsize, base;
        a = addr & 32'hFFFF_FFF8;
        if (burst == 2'b00) return a;
        if (burst == 2'b10 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
            wsize = (32'(len) + 32'd1) * 32'd8;
            base  = a - (a % wsize);
            return base + ((a - base + 32'(k) * 32'd8) % wsize);
        end
        return a + 32'(k) * 32'd8;
    endfunction

    task automatic start_ar(input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [5:0] id);
        ar_addr_i  = addr;
        ar_len_i   = len;
        ar_burst_i = burst;
        ar_id_i    = id;
        ar_valid_i = 1'b1;
        for (int t = 0; t < 50 && !ar_ready_o; t++) @(negedge clk);
        chk("ar_ready_wait", 64'(ar_ready_o), 64'd1);
        @(posedge clk);
        #1 ar_valid_i = 1'b0;
        $display("AR  addr=0x%08h len=%0d burst=%0d id=%0d", addr, len, burst, id);
    endtask

    // mode 0: grants tied high, 1: random grants, 2: skewed script (01,00,10 then 11)
    task automatic run_burst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input logic [5:0] id, input int mode, input int stop_beat, input string tag);
        int   n;
        int   g[2];
        int   b;
        int   cyc;
        logic [1:0] gv;
        logic [1:0] rexp;
        n    = int'(len) + 1;
        g[0] = 0;
        g[1] = 0;
        cyc  = 1;
        forever begin
            @(negedge clk);
            b = (g[0] < g[1]) ? g[0] : g[1];
            chk({tag, "_ar_ready"}, 64'(ar_ready_o), 64'(b >= n));
            chk({tag, "_busy"}, 64'(busy_o), 64'(b < n));
            for (int i = 0; i < 2; i++) rexp[i] = (b < n) && (g[i] == b);
            chk({tag, "_req"}, 64'(trans_rd_req_o), 64'(rexp));
            for (int i = 0; i < 2; i++) begin
                if (rexp[i]) begin
                    chk($sformatf("%s_add%0d_b%0d", tag, i, b), 64'(trans_rd_add_o[i]),
                        64'(exp_addr(addr, len, burst, b) + 32'(4 * i)));
                    chk($sformatf("%s_id%0d", tag, i), 64'(trans_rd_id_o[i]), 64'(id));
                    chk($sformatf("%s_last%0d_b%0d", tag, i, b), 64'(trans_rd_last_o[i]), 64'(b == n - 1));
                end
            end
            if (b >= n || b == stop_beat) begin
                $display("BURST %s done at cycle %0d beats=%0d", tag, cyc, b);
                return;
            end
            case (mode)
                0: gv = 2'b11;
                1: gv = 2'($urandom_range(0, 3));
                default: gv = (cyc == 1) ? 2'b01 : (cyc == 2) ? 2'b00 : (cyc == 3) ? 2'b10 : 2'b11;
            endcase
            trans_rd_gnt_i = gv;
            for (int i = 0; i < 2; i++) if (rexp[i] && gv[i]) g[i]++;
            cyc++;
            if (cyc > 400) begin
                chk({tag, "_timeout"}, 64'd1, 64'd0);
                return;
            end
        end
    endtask

    initial begin
        #12;
        chk("rst_ar_ready", 64'(ar_ready_o), 64'd1);
        chk("rst_req", 64'(trans_rd_req_o), 64'd0);
        chk("rst_add", 64'(trans_rd_add_o), 64'd0);
        chk("rst_id", 64'(trans_rd_id_o), 64'd0);
        chk("rst_last", 64'(trans_rd_last_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);

        start_ar(32'h1000_0004, 8'd3, 2'b01, 6'd5);
        run_burst(32'h1000_0004, 8'd3, 2'b01, 6'd5, 0, -1, "incr");

        start_ar(32'h2000_0030, 8'd7, 2'b10, 6'd9);
        run_burst(32'h2000_0030, 8'd7, 2'b10, 6'd9, 0, -1, "wrap");

        start_ar(32'h0000_0040, 8'd2, 2'b00, 6'd3);
        run_burst(32'h0000_0040, 8'd2, 2'b00, 6'd3, 0, -1, "fixed");

        start_ar(32'h0000_0300, 8'd1, 2'b01, 6'd12);
        run_burst(32'h0000_0300, 8'd1, 2'b01, 6'd12, 2, -1, "skew");

        start_ar(32'h5000_0000, 8'd7, 2'b01, 6'd7);
        run_burst(32'h5000_0000, 8'd7, 2'b01, 6'd7, 0, 2, "rstmid");
        #2 rst_ni = 1'b0;
        #1;
        chk("rstmid_req", 64'(trans_rd_req_o), 64'd0);
        chk("rstmid_ar_ready", 64'(ar_ready_o), 64'd1);
        chk("rstmid_busy", 64'(busy_o), 64'd0);
        chk("rstmid_last", 64'(trans_rd_last_o), 64'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        start_ar(32'h6000_0008, 8'd7, 2'b01, 6'd11);
        run_burst(32'h6000_0008, 8'd7, 2'b01, 6'd11, 0, -1, "postrst");

        start_ar(32'h7000_0000, 8'd3, 2'b01, 6'd1);
        ar_addr_i  = 32'h7100_0010;
        ar_len_i   = 8'd3;
        ar_burst_i = 2'b10;
        ar_id_i    = 6'd2;
        ar_valid_i = 1'b1;
        run_burst(32'h7000_0000, 8'd3, 2'b01, 6'd1, 1, -1, "held_a");
        start_ar(32'h7100_0010, 8'd3, 2'b10, 6'd2);
        run_burst(32'h7100_0010, 8'd3, 2'b10, 6'd2, 1, -1, "held_b");

        for (int r = 0; r < 24; r++) begin
            logic [31:0] ra;
            logic [7:0]  rl;
            logic [1:0]  rb;
            logic [5:0]  ri;
            ra = $urandom;
            rl = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 15));
            rb = 2'($urandom_range(0, 3));
            ri = 6'($urandom);
            start_ar(ra, rl, rb, ri);
            run_burst(ra, rl, rb, ri, int'($urandom_range(0, 1)), -1, $sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
